// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF spiking layer controller.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INTEG,
    ST_FIRE,
    ST_OUT
  } state_t;

  localparam int DEF_THRESH     = 100;
  localparam int DEF_LEAK_SHIFT = 4;
  localparam int DEF_REFRAC     = 2;

  // Add two sign-extended operands and clamp to a signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        width
  );
    longint sum;
    longint vmax;
    longint vmin;
    sum  = longint'(a) + longint'(b);
    vmax = (longint'(1) <<< (width - 1)) - 1;
    vmin = -vmax - 1;
    if (sum > vmax) begin
      sum = vmax;
    end else if (sum < vmin) begin
      sum = vmin;
    end
    return 32'(sum);
  endfunction

endpackage

// File: rtl/lif_neuron_unit.sv
// One leaky integrate-and-fire neuron: membrane, refractory counter, fire decision.
module lif_neuron_unit
  import snn_pkg::*;
#(
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 16,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      add_en,
  input  logic signed [W_WIDTH-1:0] w,
  input  logic                      fire_stb,
  output logic                      fire
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic signed [V_WIDTH-1:0] v;
  logic [RW-1:0]             refrac_cnt;
  logic signed [31:0]        v_ext;
  logic signed [31:0]        w_ext;
  logic signed [31:0]        v_sum;
  logic signed [31:0]        v_leak;

  // Saturating accumulate and leak candidates, plus the fire decision.
  always_comb begin
    v_ext  = 32'(v);
    w_ext  = 32'(w);
    v_sum  = sat_add(v_ext, w_ext, V_WIDTH);
    v_leak = sat_add(v_ext, -(v_ext >>> LEAK_SHIFT), V_WIDTH);
    fire   = fire_stb && (refrac_cnt == '0) && (v_leak >= THRESH);
  end

  // Membrane and refractory state update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v          <= '0;
      refrac_cnt <= '0;
    end else if (add_en && (refrac_cnt == '0)) begin
      v <= V_WIDTH'(v_sum);
    end else if (fire_stb) begin
      if (fire) begin
        v          <= '0;
        refrac_cnt <= RW'(REFRAC);
      end else begin
        v <= V_WIDTH'(v_leak);
        if (refrac_cnt != '0) begin
          refrac_cnt <= refrac_cnt - RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/snn_lif_layer_ctrl.sv
// Fully connected LIF layer: sequences one input channel per cycle across all neurons.
module snn_lif_layer_ctrl
  import snn_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int N_OUT      = 8,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 16,
  parameter int THRESH     = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC     = DEF_REFRAC,
  localparam int AW        = $clog2(N_IN * N_OUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IN-1:0]    in_spike,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_OUT-1:0]   out_spike,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               w_we,
  input  logic [AW-1:0]      w_addr,
  input  logic [W_WIDTH-1:0] w_data,
  output logic               w_drop
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t                    state;
  state_t                    state_next;
  logic [N_IN-1:0]           spike_lat;
  logic [IW-1:0]             idx;
  logic signed [W_WIDTH-1:0] w_mem [N_IN][N_OUT];
  logic [N_OUT-1:0]          fire_vec;
  logic                      last_in;
  logic                      add_en;
  logic                      fire_stb;

  assign last_in   = (idx == IW'(N_IN - 1));
  assign add_en    = (state == ST_INTEG) && spike_lat[idx];
  assign fire_stb  = (state == ST_FIRE);
  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_OUT);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: accept, integrate N_IN channels, fire, hold output until taken.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (in_valid)  state_next = ST_INTEG;
      ST_INTEG: if (last_in)   state_next = ST_FIRE;
      ST_FIRE:                 state_next = ST_OUT;
      ST_OUT:   if (out_ready) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Input latch, channel index, output spike register and dropped-write flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_lat <= '0;
      idx       <= '0;
      out_spike <= '0;
      w_drop    <= 1'b0;
    end else begin
      w_drop <= w_we && (state != ST_IDLE);
      if ((state == ST_IDLE) && in_valid) begin
        spike_lat <= in_spike;
        idx       <= '0;
      end
      if ((state == ST_INTEG) && !last_in) begin
        idx <= idx + IW'(1);
      end
      if (state == ST_FIRE) begin
        out_spike <= fire_vec;
      end
    end
  end

  // Weight file: writes land only while idle, so a same-cycle accept sees the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
          w_mem[i][j] <= '0;
        end
      end
    end else if (w_we && (state == ST_IDLE)) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
          if (w_addr == AW'(i * N_OUT + j)) begin
            w_mem[i][j] <= w_data;
          end
        end
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    lif_neuron_unit #(
      .W_WIDTH   (W_WIDTH),
      .V_WIDTH   (V_WIDTH),
      .THRESH    (THRESH),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRAC    (REFRAC)
    ) u_neuron (
      .clk     (clk),
      .reset   (reset),
      .add_en  (add_en),
      .w       (w_mem[idx][j]),
      .fire_stb(fire_stb),
      .fire    (fire_vec[j])
    );
  end

endmodule
